// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter with a Wishbone slave port (data register + CSR).
// Drives the PS/2 lines as open-drain pull-down enables and raises a latched interrupt on frame completion.
module ps2_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        irq,
    input  logic        iack,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, WAITREL} state_t;

    state_t             state;
    logic [7:0]         data_reg;
    logic [3:0]         n;
    logic [INH_W-1:0]   inh_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               ie, done, nack, err;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;

    logic        bus_req, wr_data, wr_csr, start;
    logic        active, timeout_hit, release_hit, done_set;
    logic        irq_set, irq_clr, fall, parity;
    logic [3:0]  next_n;
    logic [15:0] csr_rd;

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[15:2], wb_adr_i[0], wb_dat_i[15:8], wb_sel_i[1]};

    always_comb begin
        bus_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
        wr_data     = bus_req & wb_we_i & wb_sel_i[0] & ~wb_adr_i[1];
        wr_csr      = bus_req & wb_we_i & wb_sel_i[0] & wb_adr_i[1];
        start       = wr_data & (state == IDLE);
        active      = (state == RTS) || (state == SHIFT) || (state == WAITREL);
        timeout_hit = active && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
        release_hit = (state == WAITREL) && clk_sync && data_sync;
        done_set    = timeout_hit | release_hit;
        irq_set     = (done_set & ie) | (wr_csr & wb_dat_i[6] & ~ie & done);
        irq_clr     = start | (wr_csr & ~wb_dat_i[6]);
        fall        = clk_prev & ~clk_sync;
        parity      = ~^data_reg;
        next_n      = n + 4'd1;
        csr_rd      = {err, nack, 6'b0, done, ie, 5'b0, (state != IDLE)};
    end

    // Idle PS/2 lines are high, so synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_i;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_i;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 16'h0000;
        end else begin
            wb_ack_o <= bus_req;
            if (bus_req)
                wb_dat_o <= wb_adr_i[1] ? csr_rd : {8'h00, data_reg};
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            data_reg    <= 8'h00;
            n           <= 4'd0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            ie          <= 1'b0;
            done        <= 1'b0;
            nack        <= 1'b0;
            err         <= 1'b0;
            irq         <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            if (wr_csr)
                ie <= wb_dat_i[6];

            // iack wins over a set arriving in the same cycle.
            if (iack)
                irq <= 1'b0;
            else if (irq_set)
                irq <= 1'b1;
            else if (irq_clr)
                irq <= 1'b0;

            case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (start) begin
                        data_reg   <= wb_dat_i[7:0];
                        done       <= 1'b0;
                        nack       <= 1'b0;
                        err        <= 1'b0;
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
                        ps2_data_oe <= 1'b1;
                        to_cnt      <= '0;
                        state       <= RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                RTS, SHIFT, WAITREL: begin
                    if (timeout_hit) begin
                        err         <= 1'b1;
                        done        <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (state == RTS) begin
                            ps2_clk_oe <= 1'b0;
                            n          <= 4'd0;
                            state      <= SHIFT;
                        end else if (state == SHIFT) begin
                            // Host updates data after each device falling edge; the device samples on the rise.
                            if (fall) begin
                                n <= next_n;
                                if (next_n <= 4'd8)
                                    ps2_data_oe <= ~data_reg[n[2:0]];
                                else if (next_n == 4'd9)
                                    ps2_data_oe <= ~parity;
                                else if (next_n == 4'd10)
                                    ps2_data_oe <= 1'b0;
                                else begin
                                    nack  <= data_sync;
                                    state <= WAITREL;
                                end
                            end
                        end else if (release_hit) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: vector table of frames against a device model, plus timeout,
// busy-write, mid-frame reset and back-to-back bus corner cases.
module tb_ps2_tx;

    localparam int INH  = 40;
    localparam int TO   = 1500;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] wb_adr = '0;
    logic [15:0] wb_dat_w = '0;
    logic [15:0] wb_dat_r;
    logic        wb_cyc = 1'b0;
    logic        wb_we = 1'b0;
    logic        wb_stb = 1'b0;
    logic [1:0]  wb_sel = 2'b00;
    logic        wb_ack;
    logic        irq;
    logic        iack = 1'b0;
    logic        clk_oe, data_oe;
    logic        dev_clk = 1'b1;
    logic        dev_data = 1'b1;
    logic        clk_line, data_line;

    assign clk_line  = ~clk_oe & dev_clk;
    assign data_line = ~data_oe & dev_data;

    ps2_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
        .wb_dat_o(wb_dat_r), .wb_cyc_i(wb_cyc), .wb_we_i(wb_we), .wb_stb_i(wb_stb),
        .wb_sel_i(wb_sel), .wb_ack_o(wb_ack), .irq(irq), .iack(iack),
        .ps2_clk_i(clk_line), .ps2_data_i(data_line),
        .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  data;
        bit          dev_nack;
        bit          ie;
        logic [9:0]  exp_bits;
        logic [15:0] exp_csr;
        bit          exp_irq;
    } vec_t;

    vec_t vecs[8];

    // Reference model: the frame the device must see and the CSR after completion.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        bit par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d};
    endfunction

    function automatic logic [15:0] csr_model(input int busy, input int ie, input int done,
                                              input int nk, input int er);
        return 16'(er * 32768 + nk * 16384 + done * 128 + ie * 64 + busy);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic wb_access(input bit we, input bit adr1, input logic [15:0] wdat, output logic [15:0] rdat);
        bit got;
        got = 0;
        rdat = '0;
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = {14'b0, adr1, 1'b0};
        wb_dat_w = wdat; wb_sel = 2'b01;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wb_ack) begin
                got = 1;
                rdat = wb_dat_r;
            end
        end
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        checkOutput("bus_ack", got, 1);
    endtask

    task automatic wb_write(input bit adr1, input logic [15:0] wdat);
        logic [15:0] dummy;
        wb_access(1'b1, adr1, wdat, dummy);
    endtask

    task automatic wb_read(input bit adr1, output logic [15:0] rdat);
        wb_access(1'b0, adr1, 16'h0000, rdat);
    endtask

    task automatic measure_inhibit(output int cnt);
        cnt = 0;
        for (int i = 0; i < INH + 20 && !data_oe; i++) begin
            if (clk_oe) cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic device_frame(input bit nack_dev, output logic [9:0] bits, output bit ok);
        ok = 0;
        bits = '0;
        for (int i = 0; i < INH + 100 && !ok; i++) begin
            @(posedge clk); #1;
            if (clk_line && !data_line) ok = 1;
        end
        if (ok) begin
            for (int i = 0; i < 11; i++) begin
                repeat (HALF) @(posedge clk);
                #1 dev_clk = 0;
                repeat (HALF) @(posedge clk);
                #1 dev_clk = 1;
                if (i < 10) bits[i] = data_line;
                if (i == 9 && !nack_dev) dev_data = 0;
            end
            repeat (HALF) @(posedge clk);
            #1 dev_data = 1;
        end
    endtask

    task automatic wait_idle();
        logic [15:0] r;
        r = 16'h0001;
        for (int i = 0; i < 40 && r[0]; i++) wb_read(1'b1, r);
        checkOutput("busy_clears", r[0], 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [15:0] r;
        logic [9:0]  bits;
        bit          ok;
        int          cnt;
        wb_write(1'b1, v.ie ? 16'h0040 : 16'h0000);
        wb_write(1'b0, {8'h00, v.data});
        measure_inhibit(cnt);
        checkOutput("inhibit_cycles", cnt, INH);
        device_frame(v.dev_nack, bits, ok);
        checkOutput("start_bit_seen", ok, 1);
        checkOutput("frame_bits", bits, v.exp_bits);
        wait_idle();
        wb_read(1'b1, r);
        checkOutput("csr_after_frame", r, v.exp_csr);
        checkOutput("irq_after_frame", irq, v.exp_irq);
        wb_read(1'b0, r);
        checkOutput("data_reg", r, {8'h00, v.data});
        if (v.ie) begin
            iack = 1;
            @(posedge clk); #1;
            iack = 0;
            checkOutput("irq_after_iack", irq, 0);
        end else begin
            wb_write(1'b1, 16'h0040);
            checkOutput("irq_on_ie_rise", irq, 1);
            wb_write(1'b1, 16'h0000);
            checkOutput("irq_cleared_ie0", irq, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] r;
        logic [9:0]  bits;
        bit          ok;
        int          cnt, falls;
        bit          prev;
        vec_t        v;

        vecs[0].data = 8'hED; vecs[0].dev_nack = 0; vecs[0].ie = 1;
        vecs[1].data = 8'hFF; vecs[1].dev_nack = 1; vecs[1].ie = 1;
        for (int i = 2; i < 8; i++) begin
            vecs[i].data     = 8'($urandom_range(0, 255));
            vecs[i].dev_nack = 1'($urandom_range(0, 1));
            vecs[i].ie       = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            vecs[i].exp_bits = frame_of(vecs[i].data);
            vecs[i].exp_csr  = csr_model(0, vecs[i].ie, 1, vecs[i].dev_nack, 0);
            vecs[i].exp_irq  = vecs[i].ie;
        end

        repeat (3) @(posedge clk);
        #1 rst = 0;
        checkOutput("reset_ack", wb_ack, 0);
        checkOutput("reset_dat", wb_dat_r, 0);
        checkOutput("reset_irq", irq, 0);
        checkOutput("reset_clk_oe", clk_oe, 0);
        checkOutput("reset_data_oe", data_oe, 0);
        wb_read(1'b1, r);
        checkOutput("reset_csr", r, 0);
        wb_read(1'b0, r);
        checkOutput("reset_data_reg", r, 0);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        $display("[TB] timeout case");
        wb_write(1'b1, 16'h0040);
        wb_write(1'b0, 16'h003C);
        wb_read(1'b1, r);
        checkOutput("busy_during_frame", r, csr_model(1, 1, 0, 0, 0));
        for (int i = 0; i < INH + 20 && !data_oe; i++) begin
            @(posedge clk); #1;
        end
        cnt = 0;
        while (data_oe && cnt < TO + 10) begin
            cnt++;
            @(posedge clk); #1;
        end
        checkOutput("timeout_cycles", cnt, TO);
        checkOutput("timeout_clk_oe", clk_oe, 0);
        checkOutput("timeout_data_oe", data_oe, 0);
        wb_read(1'b1, r);
        checkOutput("timeout_csr", r, csr_model(0, 1, 1, 0, 1));
        checkOutput("timeout_irq", irq, 1);

        $display("[TB] write while busy");
        wb_write(1'b0, 16'h00ED);
        checkOutput("irq_cleared_by_start", irq, 0);
        measure_inhibit(cnt);
        fork
            device_frame(1'b0, bits, ok);
            begin
                repeat (150) @(posedge clk);
                #1 wb_write(1'b0, 16'h00F4);
            end
        join
        checkOutput("busy_write_start", ok, 1);
        checkOutput("busy_write_bits", bits, frame_of(8'hED));
        wait_idle();
        wb_read(1'b0, r);
        checkOutput("busy_write_data_reg", r, 16'h00ED);
        wb_read(1'b1, r);
        checkOutput("busy_write_csr", r, csr_model(0, 1, 1, 0, 0));

        $display("[TB] reset mid-frame");
        wb_write(1'b0, 16'h0000);
        measure_inhibit(cnt);
        fork
            device_frame(1'b0, bits, ok);
            begin
                falls = 0;
                prev = dev_clk;
                for (int i = 0; i < 2000 && falls < 5; i++) begin
                    @(posedge clk); #2;
                    if (prev && !dev_clk) falls++;
                    prev = dev_clk;
                end
                checkOutput("fifth_fall_reached", falls, 5);
                checkOutput("data_oe_before_reset", data_oe, 1);
                rst = 1;
                #1;
                checkOutput("rst_clk_oe", clk_oe, 0);
                checkOutput("rst_data_oe", data_oe, 0);
                repeat (2) @(posedge clk);
                #1 rst = 0;
            end
        join
        @(posedge clk); #1;
        wb_read(1'b1, r);
        checkOutput("csr_after_reset", r, 0);
        checkOutput("irq_after_reset", irq, 0);
        v.data = 8'hF3; v.dev_nack = 0; v.ie = 1;
        v.exp_bits = frame_of(8'hF3);
        v.exp_csr = csr_model(0, 1, 1, 0, 0);
        v.exp_irq = 1;
        applyStimulus(v);

        $display("[TB] back-to-back reads");
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 16'h0002;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("b2b_ack_%0d", k), wb_ack, (k % 2 == 0));
            if (wb_ack) checkOutput($sformatf("b2b_dat_%0d", k), wb_dat_r, csr_model(0, 1, 1, 0, 0));
        end
        wb_cyc = 0; wb_stb = 0;
        @(posedge clk); #1;
        checkOutput("no_ack_without_stb_0", wb_ack, 0);
        @(posedge clk); #1;
        checkOutput("no_ack_without_stb_1", wb_ack, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
